match_controller: RTL and testbench

//  Top-level rally/score sequencer for the pong datapath. Decides when the ball,

---
 rtl/match_controller.sv | 211 +++++++++++++++++++++
 tb/tb_match_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Rally/score sequencer for the pong datapath: serve, rally, goal freeze and match-over.
// Optional build macro MATCH_CTRL_AUTO_RESTART_EN adds an automatic restart timer in OVER.
module match_controller #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int GOAL_FRAMES  = 90
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       pause,
    input  logic       goal_p1,
    input  logic       goal_p2,
    output logic       game_rst,
    output logic       ball_en,
    output logic       serve_dir,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_RALLY = 3'd2;
    localparam logic [2:0] ST_GOAL  = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam int TMAX = (SERVE_FRAMES > GOAL_FRAMES) ? SERVE_FRAMES : GOAL_FRAMES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] SERVE_LAST = TW'(SERVE_FRAMES - 1);
    localparam logic [TW-1:0] GOAL_LAST  = TW'(GOAL_FRAMES - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

`ifdef MATCH_CTRL_AUTO_RESTART_EN
    localparam int AW = $clog2(4 * GOAL_FRAMES + 1);
    localparam logic [AW-1:0] AUTO_LAST = AW'(4 * GOAL_FRAMES - 1);
    logic [AW-1:0] aux_r, aux_s;
`endif

    logic [2:0]    state_r, state_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [3:0]    score_p1_r, score_p1_s;
    logic [3:0]    score_p2_r, score_p2_s;
    logic [1:0]    winner_r, winner_s;
    logic          serve_dir_r, serve_dir_s;
    logic          game_rst_r, game_rst_s;
    logic          ball_en_r, ball_en_s;
    logic          restart_s;

    // Scores stop at the winning value so they can never wrap.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        if (v < WIN) begin
            return v + 4'd1;
        end else begin
            return v;
        end
    endfunction

    // Next-state and next-output computation for the match sequencer.
    always_comb begin
        state_s     = state_r;
        timer_s     = timer_r;
        score_p1_s  = score_p1_r;
        score_p2_s  = score_p2_r;
        winner_s    = winner_r;
        serve_dir_s = serve_dir_r;
        game_rst_s  = 1'b0;
        restart_s   = 1'b0;
`ifdef MATCH_CTRL_AUTO_RESTART_EN
        aux_s       = aux_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s    = ST_SERVE;
                    timer_s    = '0;
                    game_rst_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (frame_tick && !pause) begin
                    if (timer_r == SERVE_LAST) begin
                        state_s = ST_RALLY;
                        timer_s = '0;
                    end else begin
                        timer_s = timer_r + TW'(1);
                    end
                end else begin
                    timer_s = timer_r;
                end
            end
            ST_RALLY: begin
                // Both flags in one clock is a replay: no point awarded.
                if (goal_p1 && goal_p2) begin
                    state_s = ST_GOAL;
                    timer_s = '0;
                end else if (goal_p1) begin
                    state_s     = ST_GOAL;
                    timer_s     = '0;
                    score_p1_s  = sat_inc(score_p1_r);
                    serve_dir_s = 1'b1;
                end else if (goal_p2) begin
                    state_s     = ST_GOAL;
                    timer_s     = '0;
                    score_p2_s  = sat_inc(score_p2_r);
                    serve_dir_s = 1'b0;
                end else begin
                    state_s = ST_RALLY;
                end
            end
            ST_GOAL: begin
                if (frame_tick && !pause) begin
                    if (timer_r == GOAL_LAST) begin
                        timer_s = '0;
                        if ((score_p1_r == WIN) || (score_p2_r == WIN)) begin
                            state_s  = ST_OVER;
                            winner_s = (score_p1_r == WIN) ? 2'b01 : 2'b10;
`ifdef MATCH_CTRL_AUTO_RESTART_EN
                            aux_s    = '0;
`endif
                        end else begin
                            state_s    = ST_SERVE;
                            game_rst_s = 1'b1;
                        end
                    end else begin
                        timer_s = timer_r + TW'(1);
                    end
                end else begin
                    timer_s = timer_r;
                end
            end
            ST_OVER: begin
                restart_s = start;
`ifdef MATCH_CTRL_AUTO_RESTART_EN
                if (!start && frame_tick) begin
                    if (aux_r == AUTO_LAST) begin
                        restart_s = 1'b1;
                    end else begin
                        aux_s = aux_r + AW'(1);
                    end
                end else begin
                    aux_s = aux_r;
                end
`endif
                if (restart_s) begin
                    state_s     = ST_SERVE;
                    timer_s     = '0;
                    game_rst_s  = 1'b1;
                    score_p1_s  = 4'd0;
                    score_p2_s  = 4'd0;
                    winner_s    = 2'b00;
                    serve_dir_s = 1'b0;
                end else begin
                    state_s = ST_OVER;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = '0;
            end
        endcase
        ball_en_s = (state_s == ST_RALLY) && !pause;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            timer_r     <= '0;
            score_p1_r  <= 4'd0;
            score_p2_r  <= 4'd0;
            winner_r    <= 2'b00;
            serve_dir_r <= 1'b0;
            game_rst_r  <= 1'b0;
            ball_en_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            timer_r     <= timer_s;
            score_p1_r  <= score_p1_s;
            score_p2_r  <= score_p2_s;
            winner_r    <= winner_s;
            serve_dir_r <= serve_dir_s;
            game_rst_r  <= game_rst_s;
            ball_en_r   <= ball_en_s;
        end
    end

`ifdef MATCH_CTRL_AUTO_RESTART_EN
    // Auto-restart counter, only meaningful while in OVER.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aux_r <= '0;
        end else begin
            aux_r <= aux_s;
        end
    end
`endif

    assign game_rst  = game_rst_r;
    assign ball_en   = ball_en_r;
    assign serve_dir = serve_dir_r;
    assign score_p1  = score_p1_r;
    assign score_p2  = score_p2_r;
    assign winner    = winner_r;
    assign state     = state_r;

endmodule

// File: tb/tb_match_controller.sv
// Directed self-checking bench for match_controller with default parameters.
module tb_match_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       start;
    logic       pause;
    logic       goal_p1;
    logic       goal_p2;
    logic       game_rst;
    logic       ball_en;
    logic       serve_dir;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [1:0] winner;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    match_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .start      (start),
        .pause      (pause),
        .goal_p1    (goal_p1),
        .goal_p2    (goal_p2),
        .game_rst   (game_rst),
        .ball_en    (ball_en),
        .serve_dir  (serve_dir),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .winner     (winner),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each frame tick is one clock high followed by one clock low.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_goal(input logic g1, input logic g2);
        goal_p1 = g1;
        goal_p2 = g2;
        @(negedge clk);
        goal_p1 = 1'b0;
        goal_p2 = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0;
        pause = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", state, 3'd0);
        check("rst_scores", {score_p1, score_p2}, 8'h00);
        check("rst_winner", winner, 2'b00);
        check("rst_outs", {game_rst, ball_en, serve_dir}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_hold", state, 3'd0);

        // Start: single game_rst pulse on entry to SERVE
        start = 1'b1;
        @(negedge clk);
        check("serve_state", state, 3'd1);
        check("serve_rst_pulse", game_rst, 1'b1);
        start = 1'b0;
        @(negedge clk);
        check("serve_rst_end", game_rst, 1'b0);

        // 30 paused ticks delay the rally by exactly 30 ticks
        tick(20);
        pause = 1'b1;
        tick(30);
        pause = 1'b0;
        tick(39);
        check("serve_paused_hold", state, 3'd1);
        tick(1);
        check("rally_state", state, 3'd2);
        check("rally_ball_en", ball_en, 1'b1);

        pause = 1'b1;
        @(negedge clk);
        check("rally_pause_ben", ball_en, 1'b0);
        check("rally_pause_state", state, 3'd2);
        pause = 1'b0;
        @(negedge clk);
        check("rally_unpause_ben", ball_en, 1'b1);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rally_start_ignored", state, 3'd2);

        // Goal level held 20 clocks scores once
        goal_p1 = 1'b1;
        repeat (20) @(negedge clk);
        goal_p1 = 1'b0;
        check("goal_state", state, 3'd3);
        check("goal_score_once", {score_p1, score_p2}, 8'h10);
        check("goal_serve_dir", serve_dir, 1'b1);
        check("goal_ben", ball_en, 1'b0);

        tick(89);
        check("goal_hold", state, 3'd3);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("goal_to_serve", state, 3'd1);
        check("goal_serve_rst", game_rst, 1'b1);
        @(negedge clk);
        check("goal_serve_rst_end", game_rst, 1'b0);
        tick(60);
        check("rally2_state", state, 3'd2);

        // Simultaneous goals: replay, nothing scored
        pulse_goal(1'b1, 1'b1);
        check("both_state", state, 3'd3);
        check("both_scores", {score_p1, score_p2}, 8'h10);
        check("both_serve_dir", serve_dir, 1'b1);
        tick(90);
        tick(60);

        pulse_goal(1'b0, 1'b1);
        check("p2_scores", {score_p1, score_p2}, 8'h11);
        check("p2_serve_dir", serve_dir, 1'b0);
        tick(90);
        tick(60);

        for (int k = 0; k < 5; k++) begin
            pulse_goal(1'b1, 1'b0);
            tick(90);
            tick(60);
        end
        check("six_one_state", state, 3'd2);
        check("six_one_scores", {score_p1, score_p2}, 8'h61);

        // Winning goal
        pulse_goal(1'b1, 1'b0);
        check("win_goal_scores", {score_p1, score_p2}, 8'h71);
        tick(89);
        check("win_goal_hold", state, 3'd3);
        tick(1);
        check("over_state", state, 3'd4);
        check("over_winner", winner, 2'b01);
        check("over_score", score_p1, 4'd7);
        check("over_ben", ball_en, 1'b0);

`ifdef MATCH_CTRL_AUTO_RESTART_EN
        tick(359);
        check("auto_hold", state, 3'd4);
        tick(1);
        check("auto_restart_state", state, 3'd1);
        check("auto_restart_scores", {score_p1, score_p2}, 8'h00);
        check("auto_restart_winner", winner, 2'b00);
`else
        tick(1000);
        check("over_no_auto", state, 3'd4);
        check("over_held_winner", winner, 2'b01);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_state", state, 3'd1);
        check("restart_scores", {score_p1, score_p2}, 8'h00);
        check("restart_winner", winner, 2'b00);
        check("restart_rst_pulse", game_rst, 1'b1);
        @(negedge clk);
`endif
        tick(60);
        check("rally3_state", state, 3'd2);

        // Asynchronous reset mid-rally
        rst_n = 1'b0;
        #1;
        check("async_rst_state", state, 3'd0);
        check("async_rst_ben", ball_en, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", state, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
